// File: rtl/package_settings_v2.sv
// Shared settings for the v2 shaping-filter datapath and its run controller.
package package_settings_v2;

  localparam int SIZE_FILTER_DATA = 14;
  localparam int FILT_W           = SIZE_FILTER_DATA + 3;

  localparam int CLEAR_CYCLES_DEFAULT  = 4;
  localparam int SETTLE_CYCLES_DEFAULT = 24;
  localparam int DEAD_CYCLES_DEFAULT   = 8;
  localparam int MAX_WIDTH_DEFAULT     = 64;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    SETTLE = 3'd2,
    ARMED  = 3'd3,
    RISING = 3'd4,
    HOLD   = 3'd5,
    DEAD   = 3'd6
  } ctrl_state_t;

endpackage

// File: rtl/v2_peak_tracker.sv
// Threshold compare, pulse-maximum / timestamp capture and pulse width counter.
module v2_peak_tracker #(
  parameter int FILT_W    = package_settings_v2::FILT_W,
  parameter int TS_W      = 32,
  parameter int MAX_WIDTH = package_settings_v2::MAX_WIDTH_DEFAULT
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     arm,
  input  logic                     track,
  input  logic signed [FILT_W-1:0] threshold,
  input  logic signed [FILT_W-1:0] filter_data,
  input  logic [TS_W-1:0]          timestamp,
  output logic                     above,
  output logic                     timeout,
  output logic signed [FILT_W-1:0] peak_data,
  output logic [TS_W-1:0]          peak_time
);
  import package_settings_v2::*;

  localparam int WW = $clog2(MAX_WIDTH + 1);

  logic [WW-1:0] width;

  assign above   = filter_data > threshold;
  assign timeout = width == WW'(MAX_WIDTH);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      peak_data <= '0;
      peak_time <= '0;
      width     <= '0;
    end else if (arm && above) begin
      peak_data <= filter_data;
      peak_time <= timestamp;
      width     <= WW'(1);
    end else if (track) begin
      // A falling-edge sample that is also the new maximum still updates the peak.
      if (filter_data > peak_data)
        peak_data <= filter_data;
      if (above && !timeout)
        width <= width + WW'(1);
    end
  end

endmodule

// File: rtl/v2_peak_ctrl.sv
// Run controller for the v2 trapezoidal filter: clear/settle sequencing,
// trigger arming, event handshake with dead time and lost-event counting.
module v2_peak_ctrl #(
  parameter int FILT_W        = package_settings_v2::FILT_W,
  parameter int TS_W          = 32,
  parameter int CLEAR_CYCLES  = package_settings_v2::CLEAR_CYCLES_DEFAULT,
  parameter int SETTLE_CYCLES = package_settings_v2::SETTLE_CYCLES_DEFAULT,
  parameter int DEAD_CYCLES   = package_settings_v2::DEAD_CYCLES_DEFAULT,
  parameter int MAX_WIDTH     = package_settings_v2::MAX_WIDTH_DEFAULT
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     stop,
  input  logic signed [FILT_W-1:0] threshold,
  input  logic signed [FILT_W-1:0] filter_data,
  output logic                     filter_rst_n,
  output logic signed [FILT_W-1:0] peak_data,
  output logic [TS_W-1:0]          peak_time,
  output logic                     peak_pileup,
  output logic                     peak_valid,
  input  logic                     peak_ready,
  output logic [15:0]              lost_cnt,
  output logic                     busy,
  output logic [2:0]               state_o
);
  import package_settings_v2::*;

  ctrl_state_t     state;
  logic [7:0]      cnt;
  logic [TS_W-1:0] timestamp;
  logic            filt_rst_q;
  logic            above_q;
  logic            above;
  logic            timeout;
  logic            crossing;
  logic            arm;
  logic            track;

  assign crossing     = above && !above_q;
  assign arm          = (state == ARMED) && !stop;
  assign track        = (state == RISING) && !stop;
  assign filter_rst_n = filt_rst_q & reset;
  assign busy         = state != IDLE;
  assign state_o      = state;

  v2_peak_tracker #(
    .FILT_W    (FILT_W),
    .TS_W      (TS_W),
    .MAX_WIDTH (MAX_WIDTH)
  ) u_tracker (
    .clk         (clk),
    .reset       (reset),
    .arm         (arm),
    .track       (track),
    .threshold   (threshold),
    .filter_data (filter_data),
    .timestamp   (timestamp),
    .above       (above),
    .timeout     (timeout),
    .peak_data   (peak_data),
    .peak_time   (peak_time)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      cnt         <= '0;
      timestamp   <= '0;
      filt_rst_q  <= 1'b0;
      above_q     <= 1'b0;
      peak_pileup <= 1'b0;
      peak_valid  <= 1'b0;
      lost_cnt    <= '0;
    end else begin
      timestamp <= timestamp + TS_W'(1);
      above_q   <= above;
      if (stop && state != IDLE) begin
        // Abort discards the pending event but keeps the captured peak registers.
        state      <= IDLE;
        cnt        <= '0;
        filt_rst_q <= 1'b0;
        peak_valid <= 1'b0;
      end else begin
        if ((state == HOLD || state == DEAD) && crossing && lost_cnt != 16'hFFFF)
          lost_cnt <= lost_cnt + 16'd1;
        case (state)
          IDLE: if (start && !stop) begin
            state <= CLEAR;
            cnt   <= '0;
          end
          CLEAR: if (cnt == 8'(CLEAR_CYCLES - 1)) begin
            state      <= SETTLE;
            cnt        <= '0;
            filt_rst_q <= 1'b1;
          end else
            cnt <= cnt + 8'd1;
          SETTLE: if (cnt == 8'(SETTLE_CYCLES - 1)) begin
            state <= ARMED;
            cnt   <= '0;
          end else
            cnt <= cnt + 8'd1;
          ARMED: if (above)
            state <= RISING;
          RISING: if (!above) begin
            state       <= HOLD;
            peak_pileup <= 1'b0;
            peak_valid  <= 1'b1;
          end else if (timeout) begin
            state       <= HOLD;
            peak_pileup <= 1'b1;
            peak_valid  <= 1'b1;
          end
          HOLD: if (peak_valid && peak_ready) begin
            state      <= DEAD;
            peak_valid <= 1'b0;
            cnt        <= '0;
          end
          DEAD: if (cnt != 8'(DEAD_CYCLES - 1))
            cnt <= cnt + 8'd1;
          else if (!above)
            state <= ARMED;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
